mem_access_controller: RTL and testbench



---
 rtl/mem_access_controller_pkg.sv | 23 ++
 rtl/mem_access_controller_if.sv | 27 ++
 rtl/mem_access_controller_wait_counter.sv | 30 +++
 rtl/mem_access_controller.sv | 138 +++++++++++++
 tb/tb_mem_access_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mem_access_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM access sequencer.
package mem_access_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int CNT_W = 4;

    // Byte address relative to the SRAM window, as a word index (wraps modulo 2^32).
    function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Pipeline request/response and SRAM pin bundle seen by the access controller.
interface mem_access_controller_if #(parameter int ADDR_W = 18);

    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       alu_result;
    logic [31:0]       st_val;
    logic              freeze;
    logic              ready;
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic              sram_we_n;
    logic              sram_oe_n;

    modport slave (
        input  mem_r_en, mem_w_en, alu_result, st_val, sram_rdata,
        output freeze, ready, rd_data, sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

    modport master (
        output mem_r_en, mem_w_en, alu_result, st_val, sram_rdata,
        input  freeze, ready, rd_data, sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

endinterface

// File: rtl/mem_access_controller_wait_counter.sv
// Loadable 4-bit down-counter timing the SRAM strobe; saturates at zero.
module wait_counter
    import mem_access_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: holds SRAM strobes for WAIT_CYCLES and freezes the pipeline meanwhile.
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
)(
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e            r_state;
    state_e            w_next;
    logic              r_op;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;
    logic [31:0]       r_rd_data;
    logic              r_we_n;
    logic              r_oe_n;
    logic              r_ready;
    logic              w_req;
    logic              w_start;
    logic              w_op_nxt;
    logic              w_cnt_zero;
    logic              w_freeze;
    logic              w_we_n_nxt;
    logic              w_oe_n_nxt;
    logic              w_ready_nxt;

    assign w_req   = bus.mem_r_en | bus.mem_w_en;
    assign w_start = (r_state == IDLE) && w_req;
    // A simultaneous read+write request is treated as a write.
    assign w_op_nxt = (r_state == IDLE) ? (bus.mem_w_en ? OP_WR : OP_RD) : r_op;

    wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start),
        .i_dec      (r_state == ACCESS),
        .i_load_val (LOAD_VAL),
        .o_zero     (w_cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE, ignoring any request.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_req ? ACCESS : IDLE;
            ACCESS:  w_next = w_cnt_zero ? DONE : ACCESS;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: combinational freeze, next values for the registered strobes and ready.
    always_comb begin
        w_freeze    = 1'b0;
        w_we_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_ready_nxt = (w_next == DONE);
        case (r_state)
            IDLE:    w_freeze = w_req;
            ACCESS:  w_freeze = 1'b1;
            DONE:    w_freeze = 1'b0;
            default: w_freeze = 1'b0;
        endcase
        if (w_next == ACCESS) begin
            w_we_n_nxt = (w_op_nxt != OP_WR);
            w_oe_n_nxt = (w_op_nxt != OP_RD);
        end else begin
            w_we_n_nxt = 1'b1;
            w_oe_n_nxt = 1'b1;
        end
    end

    // Strobes and ready come straight from flops so the SRAM pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_we_n  <= w_we_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Request capture in IDLE; address/data stay put until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_RD;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'd0;
        end else if (w_start) begin
            r_op         <= w_op_nxt;
            r_sram_addr  <= ADDR_W'(word_offset(bus.alu_result, BASE_ADDR));
            r_sram_wdata <= bus.st_val;
        end else begin
            r_op         <= r_op;
            r_sram_addr  <= r_sram_addr;
            r_sram_wdata <= r_sram_wdata;
        end
    end

    // Load data is captured on the last ACCESS edge, while OE is still asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 32'd0;
        end else if ((r_state == ACCESS) && w_cnt_zero && (r_op == OP_RD)) begin
            r_rd_data <= bus.sram_rdata;
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign bus.freeze     = rst_n & w_freeze;
    assign bus.ready      = r_ready;
    assign bus.rd_data    = r_rd_data;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.sram_we_n  = r_we_n;
    assign bus.sram_oe_n  = r_oe_n;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed, table-driven bench for mem_access_controller with a few hand-written corner sequences.
module tb_mem_access_controller;

    localparam int W = 5;

    typedef struct {
        logic        r_en;
        logic        w_en;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] rdata;
        logic [17:0] exp_addr;
        logic        exp_wr;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[7];
    vec_t post_rst;

    mem_access_controller_if #(.ADDR_W(18)) bus ();

    mem_access_controller #(.WAIT_CYCLES(W), .ADDR_W(18), .BASE_ADDR(32'd1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v, input int id);
        logic act_c;
        bus.mem_r_en   = v.r_en;
        bus.mem_w_en   = v.w_en;
        bus.alu_result = v.alu;
        bus.st_val     = v.st;
        bus.sram_rdata = v.rdata;
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            act_c = (c >= 1) && (c <= W);
            chk($sformatf("v%0d c%0d freeze", id, c), {31'd0, bus.freeze}, {31'd0, (c <= W)});
            chk($sformatf("v%0d c%0d we_n", id, c), {31'd0, bus.sram_we_n}, {31'd0, !(act_c && v.exp_wr)});
            chk($sformatf("v%0d c%0d oe_n", id, c), {31'd0, bus.sram_oe_n}, {31'd0, !(act_c && !v.exp_wr)});
            chk($sformatf("v%0d c%0d ready", id, c), {31'd0, bus.ready}, {31'd0, (c == W + 1)});
            if (c >= 1) begin
                chk($sformatf("v%0d c%0d addr", id, c), {14'd0, bus.sram_addr}, {14'd0, v.exp_addr});
                chk($sformatf("v%0d c%0d wdata", id, c), bus.sram_wdata, v.st);
            end
            if (c == W + 1) begin
                chk($sformatf("v%0d rd_data", id), bus.rd_data, v.exp_rd);
            end
            @(posedge clk);
            #1;
            // Data arriving after the access window must not be captured.
            if (c == W) bus.sram_rdata = 32'hBAD0_BAD0;
        end
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.alu_result = 32'h0000_2000;
        @(negedge clk);
        chk($sformatf("v%0d after freeze", id), {31'd0, bus.freeze}, 32'd0);
        chk($sformatf("v%0d after ready", id), {31'd0, bus.ready}, 32'd0);
        chk($sformatf("v%0d after rd_data", id), bus.rd_data, v.exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //          r_en  w_en  alu            st             rdata          addr       wr    exp_rd
        vecs[0] = '{1'b0, 1'b1, 32'd1032,      32'hDEADBEEF, 32'h0000_0000, 18'h00002, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028,      32'h1111_1111, 32'h12345678, 18'h00001, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 32'd1040,      32'hCAFEF00D, 32'h5555_5555, 18'h00004, 1'b1, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'd1024,      32'h0BADF00D, 32'hFFFF_FFFF, 18'h00000, 1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd0,         32'h2222_2222, 32'hA5A55A5A, 18'h3FF00, 1'b0, 32'hA5A55A5A};
        vecs[5] = '{1'b1, 1'b0, 32'h0010_03FC, 32'h3333_3333, 32'h0F0F1234, 18'h3FFFF, 1'b0, 32'h0F0F1234};
        vecs[6] = '{1'b0, 1'b1, 32'd1035,      32'h0000_0001, 32'h7777_7777, 18'h00002, 1'b1, 32'h0F0F1234};
        post_rst = '{1'b1, 1'b0, 32'd1028,     32'h4444_4444, 32'h600DCAFE, 18'h00001, 1'b0, 32'h600DCAFE};

        rst_n          = 1'b0;
        bus.mem_r_en   = 1'b1;
        bus.mem_w_en   = 1'b0;
        bus.alu_result = 32'd0;
        bus.st_val     = 32'd0;
        bus.sram_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst freeze", {31'd0, bus.freeze}, 32'd0);
        chk("rst ready", {31'd0, bus.ready}, 32'd0);
        chk("rst we_n", {31'd0, bus.sram_we_n}, 32'd1);
        chk("rst oe_n", {31'd0, bus.sram_oe_n}, 32'd1);
        chk("rst rd_data", bus.rd_data, 32'd0);
        chk("rst addr", {14'd0, bus.sram_addr}, 32'd0);
        chk("rst wdata", bus.sram_wdata, 32'd0);
        bus.mem_r_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d freeze", i), {31'd0, bus.freeze}, 32'd0);
            chk($sformatf("idle%0d we_n", i), {31'd0, bus.sram_we_n}, 32'd1);
            chk($sformatf("idle%0d oe_n", i), {31'd0, bus.sram_oe_n}, 32'd1);
            chk($sformatf("idle%0d ready", i), {31'd0, bus.ready}, 32'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset during cycle 3 of a store.
        bus.mem_w_en   = 1'b1;
        bus.alu_result = 32'd1032;
        bus.st_val     = 32'h9999_9999;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid we_n before rst", {31'd0, bus.sram_we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid we_n", {31'd0, bus.sram_we_n}, 32'd1);
        chk("mid oe_n", {31'd0, bus.sram_oe_n}, 32'd1);
        chk("mid freeze", {31'd0, bus.freeze}, 32'd0);
        chk("mid rd_data", bus.rd_data, 32'd0);
        bus.mem_w_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid ready in rst", {31'd0, bus.ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post%0d ready", i), {31'd0, bus.ready}, 32'd0);
            chk($sformatf("post%0d we_n", i), {31'd0, bus.sram_we_n}, 32'd1);
        end
        @(posedge clk);
        #1;
        run_txn(post_rst, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
